// File: rtl/dm_bus_pkg.sv
// Shared types and constants for the data-memory bus responder.
// Consumed by dm_bus_responder; dm_ram is self-contained.
package dm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dm_state_e;

    localparam int DM_ADDR_HI = 12;
    localparam int DM_WORDS   = 1024;

    function automatic logic [3:0] dm_lane_mask(
        input logic       sb,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'hF;
        if (sb) m = 4'b0001 << off;
        return m;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised data RAM: byte write enables, combinational read,
// asynchronous clear of every word on reset.
module dm_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dm_bus_responder.sv
// Fixed-latency data-memory responder with valid/ready request/response.
// Define DM_TRACE_EN to print a trace line for every committed store.
module dm_bus_responder #(
    parameter int LATENCY  = 2,
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_sb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    import dm_bus_pkg::*;

    localparam int AW = $clog2(DM_WORDS);

    dm_state_e   r_state;
    dm_state_e   w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_we;
    logic        r_sb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_access;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wword;
    logic [31:0] w_ram_rdata;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

    // Byte stores may be unaligned; word accesses must be aligned.
    assign w_err = (|r_addr[31:DM_ADDR_HI]) ||
                   (!(r_we && r_sb) && (|r_addr[1:0]));

    assign w_be = (w_access && r_we && !w_err) ?
                  dm_lane_mask(r_sb, r_addr[1:0]) : 4'h0;

    assign w_wword = r_sb ? {4{r_wdata[7:0]}} : r_wdata;

    dm_ram #(
        .WORDS (DM_WORDS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_idx   (r_addr[AW+1:2]),
        .i_be    (w_be),
        .i_wdata (w_wword),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) w_state_nxt = RESP;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            RESP: begin
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_sb    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_sb    <= req_sb;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (!r_we && !w_err) ? w_ram_rdata : 32'h0;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

`ifdef DM_TRACE_EN
    logic [31:0] r_pc;
    logic [31:0] w_merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_pc <= '0;
        else if (w_accept) r_pc <= req_pc;
    end

    always_comb begin
        w_merged = w_ram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) w_merged[8*b +: 8] = w_wword[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (reset && |w_be) begin
            $display("@%08h: *%08h <= %08h",
                     r_pc, {r_addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_bus_responder.sv
// Scoreboard bench for dm_bus_responder: driver queues expectations,
// a negedge monitor pops and checks each consumed response.
module tb_dm_bus_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_sb = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rise = 0;
    logic prev_v = 1'b0;

    dm_bus_responder #(
        .LATENCY  (LAT),
        .DM_WORDS (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_sb     (req_sb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            if (resp_valid && !prev_v) rise = cyc;
            prev_v = resp_valid;
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", {31'b0, resp_err}, {31'b0, e.err});
                    chk("latency", 32'(rise - e.acc), 32'(LAT));
                end
            end
        end
    end

    task automatic issue(input logic we, input logic sb,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc, input bit push,
                         input logic [31:0] er, input logic ee);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_sb    = sb;
        req_addr  = addr;
        req_wdata = wd;
        req_pc    = pc;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.acc   = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        // Scramble the bus so only latched copies can be used.
        req_valid = 1'b0;
        req_we    = ~we;
        req_sb    = ~sb;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'hA5A5_A5A5;
        req_pc    = 32'h0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || resp_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b1;

        issue(1, 0, 32'h10, 32'h1234_5678, 32'h100, 1, 32'h0, 1'b0);
        issue(0, 0, 32'h10, 32'h0, 32'h104, 1, 32'h1234_5678, 1'b0);
        issue(1, 1, 32'h13, 32'h0000_00AB, 32'h108, 1, 32'h0, 1'b0);
        issue(0, 0, 32'h10, 32'h0, 32'h10C, 1, 32'hAB34_5678, 1'b0);
        issue(1, 1, 32'h21, 32'h1122_3344, 32'h110, 1, 32'h0, 1'b0);
        issue(0, 0, 32'h20, 32'h0, 32'h114, 1, 32'h0000_4400, 1'b0);

        issue(0, 0, 32'h1002, 32'h0, 32'h118, 1, 32'h0, 1'b1);
        issue(0, 0, 32'h1000, 32'h0, 32'h11C, 1, 32'h0, 1'b1);
        issue(1, 0, 32'h12, 32'hFFFF_FFFF, 32'h120, 1, 32'h0, 1'b1);
        issue(1, 1, 32'h8000_0011, 32'hFF, 32'h124, 1, 32'h0, 1'b1);
        issue(0, 0, 32'h10, 32'h0, 32'h128, 1, 32'hAB34_5678, 1'b0);

        issue(1, 0, 32'h4, 32'h5, 32'h3000, 1, 32'h0, 1'b0);
        issue(0, 0, 32'h4, 32'h0, 32'h12C, 1, 32'h5, 1'b0);
        drain();

        // Back-pressure: response must hold while new requests are ignored.
        resp_ready = 1'b0;
        issue(0, 0, 32'h10, 32'h0, 32'h130, 1, 32'hAB34_5678, 1'b0);
        begin
            int w;
            w = 0;
            while (!resp_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, 32'hAB34_5678);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_sb    = 1'b0;
            req_addr  = 32'h10;
            req_wdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 resp_ready = 1'b1;
        issue(0, 0, 32'h10, 32'h0, 32'h134, 1, 32'hAB34_5678, 1'b0);
        drain();

        // Reset while BUSY discards the store and clears memory.
        issue(1, 0, 32'h20, 32'hFFFF_FFFF, 32'h138, 0, 32'h0, 1'b0);
        reset = 1'b0;
        #1 chk("busy_rst_valid", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        repeat (LAT + 3) @(negedge clk);
        chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        issue(0, 0, 32'h20, 32'h0, 32'h13C, 1, 32'h0, 1'b0);
        issue(0, 0, 32'h10, 32'h0, 32'h140, 1, 32'h0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_bus_responder.md
DM_BUS_RESPONDER -- requirements
Module: dm_bus_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request acceptance to memory access (legal 1..15).
REQ-002 SHALL have parameter DM_WORDS, default 1024, number of 32-bit words (4 KiB).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_sb  input  1  store is byte-wide (sb); ignored for loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data; for sb, byte in bits [7:0].
REQ-011 SHALL have port req_pc  input  32  PC of issuing instruction, trace only.
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  initiator consumes response.
REQ-014 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  request rejected (range/alignment).

Function
REQ-016 SHALL implement states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request at a rising edge with req_valid & req_ready, latching we, sb, addr, wdata, pc and loading counter with LATENCY-1, entering BUSY.
REQ-018 In BUSY, SHALL decrement counter each edge; at the edge where counter is 0, SHALL perform the memory access, load resp_rdata/resp_err, enter RESP.
REQ-019 SHALL assert resp_valid exactly in RESP and hold resp_rdata/resp_err stable until an edge with resp_ready = 1, then return to IDLE.
REQ-020 SHALL NOT accept a new request on the edge that completes a response; earliest next acceptance is one cycle later.
REQ-021 Word access: index = addr[11:2]; load returns the whole word; store overwrites it.
REQ-022 Byte store: SHALL write only lane addr[1:0] (lane 0 = bits [7:0], little-endian); other lanes unchanged.
REQ-023 SHALL flag resp_err = 1, perform no write, return rdata 0 when addr[31:12] != 0, or when a word access (load, or store with req_sb = 0) has addr[1:0] != 0.
REQ-024 req_* inputs outside the accept edge SHALL have no effect; latched copies are used throughout.

Reset
REQ-025 On reset low, SHALL immediately enter IDLE, clear counter, drive resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 1 after release.
REQ-026 Reset SHALL clear all memory words to 0; an in-flight request is discarded without writing.

Configuration
REQ-027 With DM_TRACE_EN defined, each committed store SHALL $display "@<pc hex>: *<word-aligned addr hex> <= <full resulting word hex>" at the access edge; without it, no display and identical ports and timing.

Structure
REQ-028 Shared package dm_bus_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and constants DM_ADDR_HI = 12, DM_WORDS = 1024.
REQ-029 Storage SHALL be a sub-module dm_ram: word array, 4-bit byte write enable, async reset clear, combinational read.

Verification
REQ-030 Store word 0x12345678 @0x10, then load @0x10 -> resp_rdata = 0x12345678, resp_err = 0, resp_valid exactly LATENCY cycles after accept.
REQ-031 sb 0x000000AB @0x13 onto word 0x12345678 @0x10, load @0x10 -> 0xAB345678.
REQ-032 Load @0x1002 and load @0x00001000 -> resp_err = 1, rdata 0; subsequent load @0x10 unchanged.
REQ-033 Hold resp_ready = 0 for 5 cycles -> resp_valid and data stay stable, req_ready = 0; req_valid pulses ignored.
REQ-034 Assert reset low while BUSY with store 0xFFFFFFFF @0x20 -> no response, later load @0x20 returns 0.
REQ-035 With DM_TRACE_EN, store 0x5 @0x4 with pc 0x3000 -> one line "@00003000: *00000004 <= 00000005".
